// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [2:0]      req0_alu_op,
    input  logic [6:0]      req0_alu_op_ext,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req1_alu_op,
    input  logic [6:0]      req1_alu_op_ext,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [2:0]      alu_ALU_op,
    output logic [6:0]      alu_ALU_op_ext,
    input  logic [XLEN-1:0] alu_res,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_res,
    input  logic            rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   op1_q, op2_q, res_q;
    logic [2:0]        alu_op_q;
    logic [6:0]        alu_op_ext_q;
    logic              id_q;
    logic              last_grant_q;
    logic              grant_s;
    logic              hs_s;

    // Requester selection; only meaningful on a tie is the policy choice
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant_s = ~last_grant_q;
`else
            // last_grant is still tracked, but fixed priority ignores it
            grant_s = last_grant_q & 1'b0;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Ready is held low during reset so the first acceptance follows rst deassertion
    assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant_s;
    assign req1_ready = (state_q == IDLE) && !rst && req1_valid && grant_s;
    assign hs_s       = req0_ready || req1_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and last-grant registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op1_q        <= {XLEN{1'b0}};
            op2_q        <= {XLEN{1'b0}};
            alu_op_q     <= 3'd0;
            alu_op_ext_q <= 7'd0;
            id_q         <= 1'b0;
            res_q        <= {XLEN{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (hs_s) begin
                op1_q        <= grant_s ? req1_op1 : req0_op1;
                op2_q        <= grant_s ? req1_op2 : req0_op2;
                alu_op_q     <= grant_s ? req1_alu_op : req0_alu_op;
                alu_op_ext_q <= grant_s ? req1_alu_op_ext : req0_alu_op_ext;
                id_q         <= grant_s;
                last_grant_q <= grant_s;
            end
            if (state_q == EXEC) begin
                res_q <= alu_res;
            end
        end
    end

    assign alu_op1        = op1_q;
    assign alu_op2        = op2_q;
    assign alu_ALU_op     = alu_op_q;
    assign alu_ALU_op_ext = alu_op_ext_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_id         = id_q;
    assign rsp_res        = res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a predictor queues expected responses, a monitor checks them.
module tb_alu_share_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]      req0_alu_op = '0, req1_alu_op = '0;
    logic [6:0]      req0_alu_op_ext = '0, req1_alu_op_ext = '0;
    logic [XLEN-1:0] alu_op1, alu_op2, alu_res, rsp_res;
    logic [2:0]      alu_ALU_op;
    logic [6:0]      alu_ALU_op_ext;
    logic            rsp_valid, rsp_id;
    logic            rsp_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic            id;
        logic [XLEN-1:0] res;
        int              hs_cyc;
    } exp_t;
    exp_t sb_q[$];

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_alu_op(req0_alu_op), .req0_alu_op_ext(req0_alu_op_ext),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_alu_op(req1_alu_op), .req1_alu_op_ext(req1_alu_op_ext),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_ALU_op(alu_ALU_op), .alu_ALU_op_ext(alu_ALU_op_ext),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RV32 integer ALU: funct3 selects the op, bit 5 of funct7 picks sub / arithmetic shift
    function automatic logic [XLEN-1:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic [2:0] f3, input logic [6:0] f7);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0: r = f7[5] ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    assign alu_res = alu_fn(alu_op1, alu_op2, alu_ALU_op, alu_ALU_op_ext);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction, result due two cycles after acceptance
    logic m_busy = 1'b0;
    logic m_last = 1'b1;
    int   m_resp_from = 0;
    logic e_r0, e_r1, e_rv, e_g;
    exp_t e_item;

    always @(negedge clk) begin
        e_rv = m_busy && (cyc >= m_resp_from);
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        e_g  = 1'b0;
        if (!rst && !m_busy) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                e_g = !m_last;
`else
                e_g = 1'b0;
`endif
            end else begin
                e_g = req1_valid;
            end
            e_r0 = req0_valid && !e_g;
            e_r1 = req1_valid && e_g;
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp_valid", rsp_valid, e_rv);
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            sb_q.delete();
        end else if (e_r0 || e_r1) begin
            e_item.id     = e_r1;
            e_item.res    = e_r1 ? alu_fn(req1_op1, req1_op2, req1_alu_op, req1_alu_op_ext)
                                 : alu_fn(req0_op1, req0_op2, req0_alu_op, req0_alu_op_ext);
            e_item.hs_cyc = cyc;
            sb_q.push_back(e_item);
            m_busy      = 1'b1;
            m_resp_from = cyc + 2;
            m_last      = e_r1;
        end else if (e_rv && rsp_ready) begin
            m_busy = 1'b0;
        end
    end

    // Monitor: every presented response must match the head of the scoreboard
    logic mon_seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mon_seen = 1'b0;
        end else if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual id=%0d res=%0h expected no response", rsp_id, rsp_res);
            end else begin
                chk("rsp_id", rsp_id, sb_q[0].id);
                chk("rsp_res", rsp_res, sb_q[0].res);
                if (!mon_seen) begin
                    chk("latency", cyc, sb_q[0].hs_cyc + 2);
                    mon_seen = 1'b1;
                end
                if (rsp_ready) begin
                    void'(sb_q.pop_front());
                    mon_seen = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        chk("rst_alu_op", {alu_ALU_op, alu_ALU_op_ext}, 10'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [2:0] f3, input logic [6:0] f7);
        if (id) begin
            req1_op1 = a; req1_op2 = b; req1_alu_op = f3; req1_alu_op_ext = f7; req1_valid = 1'b1;
        end else begin
            req0_op1 = a; req0_op2 = b; req0_alu_op = f3; req0_alu_op_ext = f7; req0_valid = 1'b1;
        end
    endtask

    // Presents one request and returns just after the accepting edge (first EXEC cycle)
    task automatic send(input logic id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [2:0] f3, input logic [6:0] f7);
        bit done = 1'b0;
        set_req(id, a, b, f3, f7);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_ready expected=ready for requester %0d", id);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int   order[$];
    logic exp_order[4];

    initial begin
        do_reset();

        rsp_ready = 1'b1;
        send(1'b0, 32'd5, 32'd7, 3'b000, 7'h00);
        idle_cycles(3);
        send(1'b1, 32'd3, 32'd10, 3'b000, 7'h20);
        idle_cycles(3);
        send(1'b0, 32'h8000_0000, 32'd4, 3'b101, 7'h20);
        idle_cycles(3);

        // Continuous tie for four transactions
        do_reset();
        rsp_ready = 1'b1;
        set_req(1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)), 7'h00);
        set_req(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 7'h20);
        for (int k = 0; k < 60 && order.size() < 4; k++) begin
            @(negedge clk);
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            @(posedge clk);
            #1;
            req0_op1 = $urandom;
            req1_op1 = $urandom;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        chk("tie_count", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) chk("tie_order", order[k], exp_order[k]);
        idle_cycles(4);

        // Response held for three cycles while requester 1 waits
        rsp_ready = 1'b0;
        send(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 3'b100, 7'h00);
        set_req(1'b1, 32'd9, 32'd2, 3'b001, 7'h00);
        idle_cycles(3);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 1'b1);
        @(negedge clk);
        chk("resume_ready1", req1_ready, 1'b1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        idle_cycles(4);

        // Reset during EXEC abandons the transaction
        send(1'b0, 32'd11, 32'd22, 3'b110, 7'h00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(3);
        @(negedge clk);
        chk("abort_rsp_res", rsp_res, 32'd0);
        chk("abort_rsp_id", rsp_id, 1'b0);
        chk("abort_alu_op1", alu_op1, 32'd0);
        order.delete();
        @(posedge clk);
        #1;
        set_req(1'b0, 32'd1, 32'd2, 3'b000, 7'h00);
        set_req(1'b1, 32'd3, 32'd4, 3'b000, 7'h00);
        @(negedge clk);
        chk("post_rst_tie_ready0", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        idle_cycles(4);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req0_valid      = ($urandom_range(0, 1) == 1);
            req1_valid      = ($urandom_range(0, 1) == 1);
            req0_op1        = $urandom;
            req0_op2        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            req0_alu_op     = 3'($urandom_range(0, 7));
            req0_alu_op_ext = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            req1_op1        = $urandom;
            req1_op2        = $urandom;
            req1_alu_op     = 3'($urandom_range(0, 7));
            req1_alu_op_ext = 7'($urandom_range(0, 127));
            rsp_ready       = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
